vga_scan_ctrl: RTL and testbench
================================

# vga_scan_ctrl

Parametrised VGA scan controller that replaces the fixed 640x480 timing inside the CPU/VGA top level. It derives a pixel-rate enable and a DAC clock (clk2) from the system clock and generates hsync, vsync, blank and sync. It issues per-pixel read requests with x/y coordinates to a framebuffer or CPU renderer, and returns R/G/B re-aligned with the delayed sync signals. Resolution, porches, sync polarity, clock divide, colour width and read latency are all configurable.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths, in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths, in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, active level of each sync
- CLK_DIV, 2, clk cycles per pixel; must be at least 2
- COLOR_W, 8, bits per colour channel
- RD_LAT, 2, pixel ticks from req to valid pix_r/g/b; range 1..8
- clk  in  1  system clock. This is the single clock.
- reset  in  1  asynchronous, active-high reset
- req  out  1  one-clk pulse on the pixel tick of each active pixel
- x  out  $clog2(H_ACTIVE)  column of the current req
- y  out  $clog2(V_ACTIVE)  row of the current req
- pix_r / pix_g / pix_b  in  COLOR_W  pixel data, sampled RD_LAT ticks after req
- frame_start  out  1  one-clk pulse on the tick where h=0 and v=0
- R / G / B  out  COLOR_W  colour to the DAC
- hsync / vsync  out  1  sync outputs at the configured polarity
- blank  out  1  active-low blanking to the DAC; 1 means visible
- sync  out  1  composite sync; tied to 0
- clk2  out  1  DAC clock at clk/CLK_DIV

## Operation
- The divider counter div runs 0..CLK_DIV-1. pix_en is asserted while div == CLK_DIV-1.
- clk2 is 0 while div < CLK_DIV/2 and 1 otherwise. This places the rising edge of clk2 mid-pixel; outputs change only on pix_en.
- h counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. h advances on pix_en and wraps to 0.
- v counts 0..V_TOTAL-1 and advances when h wraps.
- Active region: h < H_ACTIVE and v < V_ACTIVE. Horizontal sync is asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. Vertical sync uses the same form on v.
- On each pixel tick in the active region: req=1, x=h, y=v. Outside it, req=0 and x/y hold their last values.
- The raw sync and active bits pass through an RD_LAT-stage shift register that advances on pix_en. The pix_* inputs are registered on the same tick the delayed active bit emerges.
- R/G/B carry the pix_* values when the delayed active bit is 1, and 0 otherwise.
- Reset values for every output:
  - R/G/B: 0
  - hsync: ~HSYNC_POL
  - vsync: ~VSYNC_POL
  - blank: 0
  - clk2, req, frame_start: 0
  - x, y: 0
  - sync: 0
- Reset also clears h, v, div and the delay pipeline.
- Reset asserted mid-frame forces all of the above immediately (asynchronously). The first tick after release is h=0, v=0 and produces frame_start.

## Timing
- Pixel tick: one clk in every CLK_DIV.
- Line period: H_TOTAL·CLK_DIV clk. Frame period: H_TOTAL·V_TOTAL·CLK_DIV clk.
- req, x, y and frame_start are registered and appear the clk after the tick decision. They are high for exactly one clk.
- hsync, vsync, blank and R/G/B lag the raw counters by exactly RD_LAT pixel ticks, so colour is always aligned with its own blank/sync.
- pix_* need only be valid in the clk where the RD_LAT-th tick after req occurs.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - An input port pat_en (1 bit) is added.
  - While pat_en=1, R/G/B show 8 vertical bars, each H_ACTIVE/8 wide. Bar order: white, yellow, cyan, green, magenta, red, blue, black, each channel at full scale ('1) or 0.
  - The bars are keyed on the delayed x and apply only when the output is active.
  - req is still issued.
- VGA_TEST_PATTERN_EN undefined: the pat_en port is absent and colour always comes from pix_*.

## Structure
- vga_pkg holds:
  - default timing localparams for 640x480@60;
  - the colour-bar constant array;
  - functions h_total/v_total.
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameters ACTIVE, FP, SYNC, BP, POL;
  - inputs clk, reset, inc;
  - outputs cnt, active, sync_o, wrap.

## Test plan
All scenarios use a bench configuration of H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), CLK_DIV=2, RD_LAT=2, COLOR_W=8.

- Reset held with clk running -> R=G=B=0, hsync=vsync=1, blank=0, clk2=0, req=0.
- Release reset -> frame_start pulses once at the first tick. Line period is 28 clk, with hsync=0 for 4 clk per line, 2 ticks after h=10. frame_start repeats every 196 clk.
- vsync check -> vsync=0 for exactly one line (28 clk) per frame, covering v=5 delayed by 2 ticks.
- Bench model returns pix_r = x*16+y, 2 ticks after req -> on each tick with blank=1, R matches that expected value. 32 such ticks per frame; R=0 whenever blank=0.
- Reset pulsed while h=5 -> outputs return to reset values in the same clk. After release, req shows x=0, y=0 and frame_start=1.
- VGA_TEST_PATTERN_EN with pat_en=1 -> visible x=0..7 gives RGB FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan controller: default 640x480@60
// timing, the test-pattern colour-bar table, the per-pixel scan bits
// carried through the read-latency delay line, and total-period helpers.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Colour bars left to right, one {r,g,b} bit per channel:
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    // Raw per-pixel decisions that must stay aligned with the colour data.
    typedef struct packed {
        logic act;  // inside the visible area
        logic hs;   // horizontal sync level, polarity already applied
        logic vs;   // vertical sync level, polarity already applied
    } scan_bits_t;

    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis (horizontal or vertical): counts 0..TOTAL-1 on inc,
// decodes the visible region and the sync pulse, and flags the wrap.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b0,
    localparam int TOTAL = h_total(ACTIVE, FP, SYNC, BP),
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync_o,
    output logic         wrap
);

    assign active = int'(cnt) < ACTIVE;
    assign sync_o = (int'(cnt) >= ACTIVE + FP && int'(cnt) < ACTIVE + FP + SYNC)
                    ? POL : ~POL;
    assign wrap   = inc && (int'(cnt) == TOTAL - 1);

    // Position counter: advance on inc, return to 0 after the last position.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (inc)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Parametrised VGA scan controller. Divides clk down to a pixel tick and
// DAC clock, scans h/v, issues per-pixel framebuffer reads with x/y, and
// re-aligns the returned colour with sync/blank delayed by RD_LAT ticks.
// Optional feature: define VGA_TEST_PATTERN_EN to add the pat_en input,
// which replaces the colour with eight vertical colour bars.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 2,
    parameter int COLOR_W   = 8,
    parameter int RD_LAT    = 2,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE)
) (
    input  logic               clk,
    input  logic               reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               pat_en,
`endif
    output logic               req,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic               frame_start,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               sync,
    output logic               clk2
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam scan_bits_t IDLE_BITS = '{act: 1'b0, hs: ~HSYNC_POL, vs: ~VSYNC_POL};

    logic [DW-1:0] div, div_nxt;
    logic          pix_en;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_act, h_sync, h_wrap;
    logic          v_act, v_sync, v_wrap;
    logic          at_origin;
    scan_bits_t    raw;
    scan_bits_t    pipe [RD_LAT];
    scan_bits_t    dly;
    logic [COLOR_W-1:0] col_r, col_g, col_b;

    assign sync = 1'b0;

    // Pixel divider: tick on the last clk of each pixel.
    // NOTE: always_comb gives every output a default first so no path can infer a latch.
    always_comb begin
        pix_en  = int'(div) == CLK_DIV - 1;
        div_nxt = pix_en ? '0 : div + 1'b1;
    end

    // Divider state and registered DAC clock (low for the first half of each pixel).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= '0;
            clk2 <= 1'b0;
        end else begin
            div  <= div_nxt;
            clk2 <= int'(div_nxt) >= CLK_DIV / 2;
        end
    end

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)
    ) u_h (
        .clk(clk), .reset(reset), .inc(pix_en),
        .cnt(h), .active(h_act), .sync_o(h_sync), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)
    ) u_v (
        .clk(clk), .reset(reset), .inc(h_wrap),
        .cnt(v), .active(v_act), .sync_o(v_sync), .wrap(v_wrap)
    );

    assign raw = '{act: h_act & v_act, hs: h_sync, vs: v_sync};
    assign dly = pipe[RD_LAT-1];

    // Origin flag: set when the scan sits at h=0,v=0 (after reset or the frame wrap).
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            at_origin <= 1'b1;
        else if (pix_en)
            at_origin <= v_wrap;
    end

    // Read request, coordinates and frame marker, registered one clk after the tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req         <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            req         <= pix_en & raw.act;
            frame_start <= pix_en & at_origin;
            if (pix_en && raw.act) begin
                x <= h[XW-1:0];
                y <= v[YW-1:0];
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic [XW-1:0] xpipe [RD_LAT];
    logic [2:0]    bar;
    int            bar_i;
`endif

    // Delay line for the scan bits, matching the framebuffer read latency.
    // NOTE: the delay line is reset because its last stage feeds the outputs right after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= IDLE_BITS;
`ifdef VGA_TEST_PATTERN_EN
                xpipe[i] <= '0;
`endif
            end
        end else if (pix_en) begin
            pipe[0] <= raw;
            for (int i = 1; i < RD_LAT; i++)
                pipe[i] <= pipe[i-1];
`ifdef VGA_TEST_PATTERN_EN
            xpipe[0] <= h[XW-1:0];
            for (int i = 1; i < RD_LAT; i++)
                xpipe[i] <= xpipe[i-1];
`endif
        end
    end

    // Colour source: framebuffer data, or the colour bars keyed on the delayed column.
    always_comb begin
        col_r = pix_r;
        col_g = pix_g;
        col_b = pix_b;
`ifdef VGA_TEST_PATTERN_EN
        bar_i = int'(xpipe[RD_LAT-1]) / BAR_W;
        bar   = (bar_i > 7) ? 3'd7 : 3'(bar_i);
        if (pat_en) begin
            col_r = {COLOR_W{BAR_RGB[bar][2]}};
            col_g = {COLOR_W{BAR_RGB[bar][1]}};
            col_b = {COLOR_W{BAR_RGB[bar][0]}};
        end
`endif
    end

    // DAC outputs: delayed sync/blank and colour gated by the delayed active bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            R     <= '0;
            G     <= '0;
            B     <= '0;
            hsync <= ~HSYNC_POL;
            vsync <= ~VSYNC_POL;
            blank <= 1'b0;
        end else if (pix_en) begin
            hsync <= dly.hs;
            vsync <= dly.vs;
            blank <= dly.act;
            R     <= dly.act ? col_r : '0;
            G     <= dly.act ? col_g : '0;
            B     <= dly.act ? col_b : '0;
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl on a reduced 8x4 raster
// (H 8/2/2/2, V 4/1/1/1, CLK_DIV=2, RD_LAT=2). A position-arithmetic model
// checks every output on every falling edge; a framebuffer responder returns
// x*16+y for each request; literal checks pin periods and counts.
module tb_vga_scan_ctrl;

    localparam int CLK_DIV = 2;
    localparam int RD_LAT  = 2;
    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HT = 14;
    localparam int VT = 7;
    localparam logic [7:0] JUNK = 8'hC3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix_r = JUNK;
    logic [7:0] pix_g = JUNK;
    logic [7:0] pix_b = JUNK;
    logic       req, frame_start, hsync, vsync, blank, sync, clk2;
    logic [2:0] x;
    logic [1:0] y;
    logic [7:0] R, G, B;
`ifdef VGA_TEST_PATTERN_EN
    logic       pat_en = 1'b0;
`endif

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int checks = 0;
    int errors = 0;
    bit pat_mode = 1'b0;

    always #5 clk = ~clk;

    vga_scan_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .CLK_DIV(CLK_DIV), .COLOR_W(8), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(rst),
`ifdef VGA_TEST_PATTERN_EN
        .pat_en(pat_en),
`endif
        .req(req), .x(x), .y(y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start),
        .R(R), .G(G), .B(B),
        .hsync(hsync), .vsync(vsync), .blank(blank), .sync(sync), .clk2(clk2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the raster: pixel position p counts ticks from the origin.
    function automatic int mh(input int p);
        return p % HT;
    endfunction
    function automatic int mv(input int p);
        return (p / HT) % VT;
    endfunction
    function automatic bit mact(input int p);
        return mh(p) < HA && mv(p) < VA;
    endfunction
    function automatic logic [7:0] pixval(input int xx, input int yy);
        return 8'(xx * 16 + yy);
    endfunction

    // Model state: n = rising edges since reset release.
    int n, lt, p;
    bit tick, eact, ehs, evs;
    logic [2:0] ex_x;
    logic [1:0] ex_y;
    logic [7:0] val, er, eg, eb;
    logic [7:0] resp [RD_LAT];

    // Per-cycle compare against the model, then framebuffer responder.
    always @(negedge clk) begin
        if (rst) begin
            n = 0;
            ex_x = '0;
            ex_y = '0;
            for (int i = 0; i < RD_LAT; i++) resp[i] = JUNK;
            pix_r = JUNK; pix_g = JUNK; pix_b = JUNK;
            check("rst_R", R, 0);
            check("rst_G", G, 0);
            check("rst_B", B, 0);
            check("rst_hsync", hsync, 1);
            check("rst_vsync", vsync, 1);
            check("rst_blank", blank, 0);
            check("rst_clk2", clk2, 0);
            check("rst_req", req, 0);
            check("rst_frame_start", frame_start, 0);
            check("rst_x", x, 0);
            check("rst_y", y, 0);
            check("rst_sync", sync, 0);
        end else begin
            n++;
            tick = (n % CLK_DIV) == 0;
            lt   = n / CLK_DIV - 1;
            check("clk2", clk2, (n % CLK_DIV) >= CLK_DIV / 2);
            check("req", req, tick && mact(lt));
            check("frame_start", frame_start, tick && (lt % (HT * VT) == 0));
            if (tick && mact(lt)) begin
                ex_x = 3'(mh(lt));
                ex_y = 2'(mv(lt));
            end
            check("x", x, ex_x);
            check("y", y, ex_y);
            p = lt - RD_LAT;
            if (p < 0) begin
                eact = 1'b0; ehs = 1'b1; evs = 1'b1;
            end else begin
                eact = mact(p);
                ehs  = !(mh(p) >= 10 && mh(p) < 12);
                evs  = !(mv(p) == 5);
            end
            er = '0; eg = '0; eb = '0;
            if (eact) begin
                if (pat_mode) begin
                    {er, eg, eb} = bars[mh(p)];
                end else begin
                    val = pixval(mh(p), mv(p));
                    er = val; eg = ~val; eb = val ^ 8'h5A;
                end
            end
            check("blank", blank, eact);
            check("hsync", hsync, ehs);
            check("vsync", vsync, evs);
            check("R", R, er);
            check("G", G, eg);
            check("B", B, eb);
            check("sync", sync, 0);
            // Responder: data valid only in the clk ending with the RD_LAT-th tick.
            if (tick) begin
                for (int i = RD_LAT - 1; i > 0; i--) resp[i] = resp[i-1];
                resp[0] = req ? pixval(int'(x), int'(y)) : JUNK;
                pix_r = JUNK; pix_g = JUNK; pix_b = JUNK;
            end else begin
                pix_r = resp[RD_LAT-1];
                pix_g = ~resp[RD_LAT-1];
                pix_b = resp[RD_LAT-1] ^ 8'h5A;
            end
        end
    end

    task automatic wait_fs(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int hs_lo, vs_lo, bl_hi, fs_cnt, fs_at, t0, t1, lowrun;
        bit prev;

        // Reset held with the clock running.
        repeat (4) @(negedge clk);
        #1;
        check("hold_R", R, 0);
        check("hold_hsync", hsync, 1);
        check("hold_vsync", vsync, 1);
        check("hold_blank", blank, 0);
        check("hold_clk2", clk2, 0);
        check("hold_req", req, 0);

        // Release; first tick is the origin.
        @(negedge clk); #1 rst = 1'b0;
        wait_fs(8, ok);
        check("first_frame_start_seen", ok, 1);

        // One frame of counts following the frame marker.
        hs_lo = 0; vs_lo = 0; bl_hi = 0; fs_cnt = 0; fs_at = 0;
        for (int i = 1; i <= HT * VT * CLK_DIV; i++) begin
            @(negedge clk);
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (blank) bl_hi++;
            if (frame_start) begin
                fs_cnt++;
                fs_at = i;
            end
        end
        check("hsync_low_clk_per_frame", hs_lo, 28);
        check("vsync_low_clk_per_frame", vs_lo, 28);
        check("visible_clk_per_frame", bl_hi, 64);
        check("frame_start_count", fs_cnt, 1);
        check("frame_period_clk", fs_at, 196);

        // Line period and hsync pulse width.
        prev = hsync; t0 = -1; t1 = -1; lowrun = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (prev && !hsync) begin
                if (t0 < 0) t0 = i;
                else if (t1 < 0) t1 = i;
            end
            if (t0 >= 0 && t1 < 0 && !hsync) lowrun++;
            prev = hsync;
        end
        check("line_period_clk", t1 - t0, 28);
        check("hsync_width_clk", lowrun, 4);

        // Reset while h=5 on a visible line.
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req && x == 3'd4 && y == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        check("found_h5", ok, 1);
        check("pre_reset_R", R, 8'h21);
        check("pre_reset_blank", blank, 1);
        #1 rst = 1'b1;
        #1;
        check("async_R", R, 0);
        check("async_G", G, 0);
        check("async_blank", blank, 0);
        check("async_hsync", hsync, 1);
        check("async_vsync", vsync, 1);
        check("async_req", req, 0);
        check("async_x", x, 0);
        check("async_y", y, 0);
        check("async_clk2", clk2, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req) begin
                ok = 1'b1;
                break;
            end
        end
        check("restart_req_seen", ok, 1);
        check("restart_x", x, 0);
        check("restart_y", y, 0);
        check("restart_frame_start", frame_start, 1);
        repeat (220) @(negedge clk);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars on the first visible line.
        @(negedge clk);
        #1 rst = 1'b1;
        pat_en = 1'b1;
        pat_mode = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bar_%0d", k), {R, G, B}, bars[k]);
            repeat (2) @(negedge clk);
        end
        repeat (200) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
